csb_seq: RTL and testbench
==========================

Name: csb_seq

Overview:
- Parametrised command sequencer; successor to the single-engine command/status block.
- Loads compressed layer commands into the command FIFO, then parses each CMD_WORDS-word command.
- Per command: drives the selected engine handshake and DMA read-port mask, counts output-channel beats, advances the writeback address and raises irq after exactly cmd_size commands.
- Sits between the okHost/SDRAM command FIFO and the conv/maxpool/avepool engines.

Parameters:
CMD_WORDS, 6, 32-bit words per command (min 6; words 7+ consumed and discarded)
N_PAR, 16, output channels completed per engine valid beat
NUM_ENG, 3, engine handshake pairs (0 conv, 1 maxpool, 2 avepool)
NUM_PORT, 4, DMA read ports
WB_STRIDE, 64, writeback_addr increment (bytes) per beat
TIMEOUT_CYC, 65535, watchdog limit (CSB_TIMEOUT_EN only)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
op_en  in  1  start pulse; sampled in IDLE only
cmd_size  in  7  number of commands in this run
cmd_fifo_wr_count  in  16  FIFO write-side word count
cmd_load_en  out  1  DMA command-load request (was p0_reads_en during load)
cmd  in  32  FIFO head word (first-word-fall-through)
cmd_fifo_empty  in  1  FIFO empty
cmd_fifo_rd_en  out  1  pop; combinational = (state==FETCH) & !cmd_fifo_empty
eng_valid  in  NUM_ENG  per-engine beat done
eng_ready  out  NUM_ENG  per-engine enable/ready
port_reads_en  out  NUM_PORT  DMA read enables
op_type  out  3  decoded op
padding  out  1  pad flag
stride_1  out  8  line stride
stride_2  out  16  surface stride
i_channel_size, o_channel_size  out  16 each  channel counts
i_kernel_size, o_kernel_size  out  8 each  kernel sizes
weight_start_addr, data_start_addr  out  32 each  DMA bases
writeback_addr  out  32  current writeback address
op_run  out  1  high from first ISSUE until FINISH
cmd_done_count  out  7  commands retired
err  out  1  sticky error
irq  out  1  run-complete interrupt
irq_clr  in  1  acknowledge; returns to IDLE

Behaviour:
- Reset: every output 0, state IDLE. Mid-run reset aborts immediately; no partial handshake is preserved.
- States: IDLE -> FETCH -> ISSUE -> WAIT -> (FETCH | FINISH); FINISH -> IDLE on irq_clr.
- IDLE:
  - op_en with cmd_size==0: go to FINISH next cycle.
  - op_en with cmd_size!=0: go to FETCH; set cmd_load_en, clear cmd_done_count and err.
- cmd_load_en: clears on the first cycle cmd_fifo_wr_count >= cmd_size*CMD_WORDS (16-bit product). Independent of state.
- FETCH:
  - Word index w runs 0..CMD_WORDS-1; a word is consumed only on a cycle with rd_en high. FIFO empty stalls with no timeout.
  - w0: op_type=[2:0], padding=[3], stride_1=[15:8], stride_2=[31:16].
  - w1: i_ch=[15:0], o_ch=[31:16].
  - w2: i_k=[7:0], o_k=[23:16].
  - w3: weight addr. w4: data addr. w5: writeback base.
  - Last word consumed -> ISSUE.
- ISSUE (1 cycle):
  - op 1/2/3 -> engine 0; 4 -> engine 1; 5 -> engine 2.
  - Port masks: op1 ports {2,3}; op2/4/5 {0,1}; op3 {0..3}. Bits at index >= NUM_PORT dropped.
  - Set eng_ready[e] and port_reads_en, clear beat counter n, set op_run.
  - op 0/6/7, or engine index >= NUM_ENG: set err, retire the command without a handshake.
- WAIT:
  - Beat = eng_valid[e] & eng_ready[e]. Per beat: n += N_PAR, writeback_addr += WB_STRIDE. Valid on non-selected engines is ignored.
  - Last beat: n+N_PAR >= o_channel_size; o_channel_size==0 means one beat.
  - Registered response to the last beat: eng_ready and port_reads_en clear, cmd_done_count increments.
  - Next state is FINISH if new count==cmd_size, else FETCH. The FIFO-empty flag is never used for termination.
- FINISH: op_run=0, irq=1 held until irq_clr; then IDLE with irq=0. op_en ignored outside IDLE.
- Simultaneous irq_clr and op_en in FINISH: clear only; op_en is not latched.
- Arithmetic: n is 17 bits, so the compare cannot wrap. writeback_addr wraps modulo 2^32.

Optional Feature:
- Macro CSB_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog clears on ISSUE and on each beat, and counts in WAIT.
  - Reaching TIMEOUT_CYC: clear eng_ready/port_reads_en, set err, retire the command as if the last beat had arrived.
- Undefined: no watchdog logic; WAIT can wait indefinitely.

Test Plan:
- cmd_size=1, op 1 conv1x1, o_ch=64, 4 valid beats -> port_reads_en=4'b1100, eng_ready=3'b001; writeback_addr base+256; cmd_done_count=1; irq 1 cycle after the 4th beat.
- cmd_size=3 (op 2, 4, 5), o_ch=16 each -> eng_ready 001, 010, 100 in turn; masks 0011 each; irq only after the third retire; op_run low in FINISH.
- FIFO empties mid-command (stall 5 cycles at w3) -> fields intact, no extra pops, total rd_en pulses = 6*cmd_size.
- op_type 7 in command 1 of 2 -> err=1, no eng_ready; command 2 executes; irq with err still 1.
- cmd_size=0 -> FINISH directly, irq=1, no rd_en; irq_clr -> IDLE, irq=0. Reset asserted during WAIT -> all outputs 0 same cycle.
- CSB_TIMEOUT_EN, TIMEOUT_CYC=100, no valid -> ready drops 100 cycles after ISSUE; err=1; cmd_done_count=1.

Source files
------------

// File: rtl/csb_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : csb_seq_if
//  Description : Bus bundle between csb_seq and its neighbours: the command
//                FIFO (first-word-fall-through head, pop, fill level, load
//                request) plus the engine handshakes and DMA read enables.
//                master = sequencer side, slave = FIFO/engine/DMA side.
//  Signals     : cmd_fifo_wr_count[15:0] FIFO write-side word count
//                cmd_load_en              DMA command-load request
//                cmd[31:0]                FIFO head word
//                cmd_fifo_empty           FIFO empty
//                cmd_fifo_rd_en           FIFO pop
//                eng_valid[NUM_ENG-1:0]   per-engine beat done
//                eng_ready[NUM_ENG-1:0]   per-engine enable/ready
//                port_reads_en[NUM_PORT-1:0] DMA read enables
//  Revision    : 1.0  initial release
// ============================================================================
interface csb_seq_if #(
  parameter int NUM_ENG  = 3,
  parameter int NUM_PORT = 4
);
  logic [15:0]         cmd_fifo_wr_count;
  logic                cmd_load_en;
  logic [31:0]         cmd;
  logic                cmd_fifo_empty;
  logic                cmd_fifo_rd_en;
  logic [NUM_ENG-1:0]  eng_valid;
  logic [NUM_ENG-1:0]  eng_ready;
  logic [NUM_PORT-1:0] port_reads_en;

  modport master (
    input  cmd_fifo_wr_count, cmd, cmd_fifo_empty, eng_valid,
    output cmd_load_en, cmd_fifo_rd_en, eng_ready, port_reads_en
  );

  modport slave (
    output cmd_fifo_wr_count, cmd, cmd_fifo_empty, eng_valid,
    input  cmd_load_en, cmd_fifo_rd_en, eng_ready, port_reads_en
  );
endinterface
`default_nettype wire

// File: rtl/csb_seq.sv
`default_nettype none
// ============================================================================
//  Module      : csb_seq
//  Description : Parametrised command sequencer. Pops CMD_WORDS-word layer
//                commands from the command FIFO, drives the selected engine
//                handshake and DMA read-port mask, counts output-channel
//                beats, advances the writeback address and raises irq once
//                cmd_size commands have retired.
//  Optional    : `define CSB_TIMEOUT_EN adds a WAIT-state watchdog that
//                retires a stuck command after TIMEOUT_CYC cycles with err.
//  Ports       : clk, rst_n (async active-low)
//                bus      csb_seq_if.master  FIFO + engine/DMA handshakes
//                op_en, cmd_size           run start / command count
//                op_type..writeback_addr   decoded command fields
//                op_run, cmd_done_count, err, irq / irq_clr  run status
//  Revision    : 1.0  initial release
// ============================================================================
module csb_seq #(
  parameter int CMD_WORDS   = 6,
  parameter int N_PAR       = 16,
  parameter int NUM_ENG     = 3,
  parameter int NUM_PORT    = 4,
  parameter int WB_STRIDE   = 64,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  csb_seq_if.master   bus,
  input  logic        op_en,
  input  logic [6:0]  cmd_size,
  output logic [2:0]  op_type,
  output logic        padding,
  output logic [7:0]  stride_1,
  output logic [15:0] stride_2,
  output logic [15:0] i_channel_size,
  output logic [15:0] o_channel_size,
  output logic [7:0]  i_kernel_size,
  output logic [7:0]  o_kernel_size,
  output logic [31:0] weight_start_addr,
  output logic [31:0] data_start_addr,
  output logic [31:0] writeback_addr,
  output logic        op_run,
  output logic [6:0]  cmd_done_count,
  output logic        err,
  output logic        irq,
  input  logic        irq_clr
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  localparam int WIDX_W = $clog2(CMD_WORDS);

  logic [2:0]          r_state;
  logic [WIDX_W-1:0]   r_widx;
  logic [16:0]         r_n;
  logic                r_load_en;
  logic [NUM_ENG-1:0]  r_eng_ready;
  logic [NUM_PORT-1:0] r_port_en;

  logic [1:0]          w_eng_idx;
  logic                w_op_ok;
  logic                w_eng_ok;
  logic [3:0]          w_mask4;
  logic [NUM_ENG-1:0]  w_eng_onehot;
  logic [NUM_PORT-1:0] w_port_mask;
  logic [15:0]         w_load_words;
  logic                w_beat;
  logic [16:0]         w_n_next;
  logic                w_last;
  logic                w_timeout;
  logic                w_retire;
  logic [6:0]          w_cnt_inc;
  logic                w_unused;

  assign bus.cmd_fifo_rd_en = (r_state == S_FETCH) && !bus.cmd_fifo_empty;
  assign bus.cmd_load_en    = r_load_en;
  assign bus.eng_ready      = r_eng_ready;
  assign bus.port_reads_en  = r_port_en;

  // 16-bit product on purpose: the DMA word counter is 16 bits wide too.
  assign w_load_words = 16'(cmd_size) * 16'(CMD_WORDS);

  // Op decode: engine index and a 4-port mask before trimming to NUM_PORT.
  always_comb begin
    w_eng_idx = 2'd0;
    w_op_ok   = 1'b1;
    w_mask4   = 4'b0000;
    case (op_type)
      3'd1:    w_mask4 = 4'b1100;
      3'd2:    w_mask4 = 4'b0011;
      3'd3:    w_mask4 = 4'b1111;
      3'd4:    begin w_eng_idx = 2'd1; w_mask4 = 4'b0011; end
      3'd5:    begin w_eng_idx = 2'd2; w_mask4 = 4'b0011; end
      default: w_op_ok = 1'b0;
    endcase
  end

  assign w_eng_ok = w_op_ok && (int'(w_eng_idx) < NUM_ENG);

  always_comb begin
    w_eng_onehot = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      w_eng_onehot[i] = (int'(w_eng_idx) == i);
    end
    w_port_mask = '0;
    for (int p = 0; p < NUM_PORT; p++) begin
      w_port_mask[p] = (p < 4) ? w_mask4[p[1:0]] : 1'b0;
    end
  end

  // r_eng_ready is one-hot on the selected engine, so valid elsewhere is masked.
  assign w_beat    = (r_state == S_WAIT) && |(bus.eng_valid & r_eng_ready);
  assign w_n_next  = r_n + 17'(N_PAR);
  assign w_last    = w_n_next >= {1'b0, o_channel_size};
  assign w_cnt_inc = cmd_done_count + 7'd1;

`ifdef CSB_TIMEOUT_EN
  logic [15:0] r_wdog;
  assign w_timeout = (r_state == S_WAIT) && !w_beat && (r_wdog == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= 16'd0;
    end else if (r_state == S_ISSUE || w_beat) begin
      r_wdog <= 16'd0;
    end else if (r_state == S_WAIT) begin
      r_wdog <= r_wdog + 16'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // A command retires on its last beat, on a watchdog expiry, or straight
  // from ISSUE when the op cannot be mapped to an engine.
  always_comb begin
    w_retire = 1'b0;
    if (r_state == S_ISSUE) w_retire = !w_eng_ok;
    if (r_state == S_WAIT)  w_retire = (w_beat && w_last) || w_timeout;
  end

  // Command bits with no field in them, plus a configuration value only the
  // optional watchdog consumes.
  assign w_unused = ^{bus.cmd[7:4], (TIMEOUT_CYC == 0)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= S_IDLE;
      r_widx            <= '0;
      r_n               <= 17'd0;
      r_load_en         <= 1'b0;
      r_eng_ready       <= '0;
      r_port_en         <= '0;
      op_type           <= 3'd0;
      padding           <= 1'b0;
      stride_1          <= 8'd0;
      stride_2          <= 16'd0;
      i_channel_size    <= 16'd0;
      o_channel_size    <= 16'd0;
      i_kernel_size     <= 8'd0;
      o_kernel_size     <= 8'd0;
      weight_start_addr <= 32'd0;
      data_start_addr   <= 32'd0;
      writeback_addr    <= 32'd0;
      op_run            <= 1'b0;
      cmd_done_count    <= 7'd0;
      err               <= 1'b0;
      irq               <= 1'b0;
    end else begin
      // Load request runs on its own, independent of the sequencer state.
      if (r_state == S_IDLE && op_en && cmd_size != 7'd0) begin
        r_load_en <= 1'b1;
      end else if (r_load_en && bus.cmd_fifo_wr_count >= w_load_words) begin
        r_load_en <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (op_en) begin
            if (cmd_size == 7'd0) begin
              r_state <= S_FINISH;
              irq     <= 1'b1;
            end else begin
              r_state        <= S_FETCH;
              r_widx         <= '0;
              cmd_done_count <= 7'd0;
              err            <= 1'b0;
            end
          end
        end
        S_FETCH: begin
          if (bus.cmd_fifo_rd_en) begin
            case (int'(r_widx))
              0: begin
                op_type  <= bus.cmd[2:0];
                padding  <= bus.cmd[3];
                stride_1 <= bus.cmd[15:8];
                stride_2 <= bus.cmd[31:16];
              end
              1: begin
                i_channel_size <= bus.cmd[15:0];
                o_channel_size <= bus.cmd[31:16];
              end
              2: begin
                i_kernel_size <= bus.cmd[7:0];
                o_kernel_size <= bus.cmd[23:16];
              end
              3:       weight_start_addr <= bus.cmd;
              4:       data_start_addr   <= bus.cmd;
              5:       writeback_addr    <= bus.cmd;
              default: ;  // trailing words are popped and dropped
            endcase
            if (r_widx == WIDX_W'(CMD_WORDS - 1)) begin
              r_widx  <= '0;
              r_state <= S_ISSUE;
            end else begin
              r_widx <= r_widx + WIDX_W'(1);
            end
          end
        end
        S_ISSUE: begin
          op_run <= 1'b1;
          r_n    <= 17'd0;
          if (w_eng_ok) begin
            r_eng_ready <= w_eng_onehot;
            r_port_en   <= w_port_mask;
            r_state     <= S_WAIT;
          end else begin
            err <= 1'b1;
          end
        end
        S_WAIT: begin
          if (w_beat) begin
            r_n            <= w_n_next;
            writeback_addr <= writeback_addr + 32'(WB_STRIDE);
          end
          if (w_timeout) err <= 1'b1;
        end
        S_FINISH: begin
          if (irq_clr) begin
            irq     <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Retirement overrides the per-state next-state choice above.
      if (w_retire) begin
        r_eng_ready    <= '0;
        r_port_en      <= '0;
        cmd_done_count <= w_cnt_inc;
        if (w_cnt_inc == cmd_size) begin
          r_state <= S_FINISH;
          irq     <= 1'b1;
          op_run  <= 1'b0;
        end else begin
          r_state <= S_FETCH;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csb_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csb_seq
//  Description : Self-checking bench for csb_seq. A FIFO model feeds command
//                words; expected engine/port masks, beat counts and
//                writeback addresses come from a command-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_csb_seq;
  localparam int N_PAR     = 16;
  localparam int WB_STRIDE = 64;

  typedef struct {
    logic [2:0]  op;
    logic        pad;
    logic [7:0]  s1;
    logic [15:0] s2;
    logic [15:0] ich;
    logic [15:0] och;
    logic [7:0]  ik;
    logic [7:0]  ok;
    logic [31:0] wa;
    logic [31:0] da;
    logic [31:0] wb;
  } cmd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csb_seq_if #(.NUM_ENG(3), .NUM_PORT(4)) bus();

  logic        op_en = 1'b0;
  logic        irq_clr = 1'b0;
  logic [6:0]  cmd_size = 7'd0;
  logic [2:0]  op_type;
  logic        padding;
  logic [7:0]  stride_1;
  logic [15:0] stride_2;
  logic [15:0] i_channel_size;
  logic [15:0] o_channel_size;
  logic [7:0]  i_kernel_size;
  logic [7:0]  o_kernel_size;
  logic [31:0] weight_start_addr;
  logic [31:0] data_start_addr;
  logic [31:0] writeback_addr;
  logic        op_run;
  logic [6:0]  cmd_done_count;
  logic        err;
  logic        irq;

  csb_seq dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus               (bus),
    .op_en             (op_en),
    .cmd_size          (cmd_size),
    .op_type           (op_type),
    .padding           (padding),
    .stride_1          (stride_1),
    .stride_2          (stride_2),
    .i_channel_size    (i_channel_size),
    .o_channel_size    (o_channel_size),
    .i_kernel_size     (i_kernel_size),
    .o_kernel_size     (o_kernel_size),
    .weight_start_addr (weight_start_addr),
    .data_start_addr   (data_start_addr),
    .writeback_addr    (writeback_addr),
    .op_run            (op_run),
    .cmd_done_count    (cmd_done_count),
    .err               (err),
    .irq               (irq),
    .irq_clr           (irq_clr)
  );

  // First-word-fall-through FIFO model.
  logic [31:0] fifo_mem [0:255];
  int rd_ptr = 0;
  int wr_ptr = 0;
  int pops   = 0;
  assign bus.cmd            = fifo_mem[rd_ptr[7:0]];
  assign bus.cmd_fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (bus.cmd_fifo_rd_en) begin
      rd_ptr <= rd_ptr + 1;
      pops   <= pops + 1;
    end
  end

  int   tests = 0;
  int   fails = 0;
  int   exp_done = 0;
  logic run_err = 1'b0;
  cmd_t cs[$];
  cmd_t c;
  int   p0;
  int   guard;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- command-level reference model ----------------
  function automatic logic [2:0] exp_eng(input logic [2:0] op);
    if (op >= 3'd1 && op <= 3'd3) return 3'b001;
    if (op == 3'd4) return 3'b010;
    if (op == 3'd5) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [3:0] exp_ports(input logic [2:0] op);
    if (op == 3'd1) return 4'b1100;
    if (op == 3'd3) return 4'b1111;
    if (op == 3'd2 || op == 3'd4 || op == 3'd5) return 4'b0011;
    return 4'b0000;
  endfunction

  function automatic int exp_beats(input logic [15:0] och);
    if (och == 16'd0) return 1;
    return (int'(och) + N_PAR - 1) / N_PAR;
  endfunction

  function automatic logic [31:0] cmd_word(input cmd_t x, input int w);
    logic [31:0] j;
    j = $urandom;  // filler for bits no field uses
    case (w)
      0:       return {x.s2, x.s1, j[7:4], x.pad, x.op};
      1:       return {x.och, x.ich};
      2:       return {j[31:24], x.ok, j[15:8], x.ik};
      3:       return x.wa;
      4:       return x.da;
      default: return x.wb;
    endcase
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t x;
    x.op = 3'($urandom_range(1, 5));
    if ($urandom_range(0, 7) == 0) begin
      case ($urandom_range(0, 2))
        0:       x.op = 3'd0;
        1:       x.op = 3'd6;
        default: x.op = 3'd7;
      endcase
    end
    x.pad = 1'($urandom);
    x.s1  = 8'($urandom);
    x.s2  = 16'($urandom);
    x.ich = 16'($urandom);
    x.och = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 80));
    x.ik  = 8'($urandom);
    x.ok  = 8'($urandom);
    x.wa  = $urandom;
    x.da  = $urandom;
    x.wb  = $urandom;
    return x;
  endfunction

  task automatic push_words(input cmd_t x, input int from, input int upto);
    for (int w = from; w <= upto; w++) begin
      fifo_mem[wr_ptr[7:0]] = cmd_word(x, w);
      wr_ptr++;
    end
  endtask

  task automatic start_run(input logic [6:0] n, input logic [15:0] wc);
    @(negedge clk);
    cmd_size = n;
    bus.cmd_fifo_wr_count = wc;
    op_en = 1'b1;
    @(negedge clk);
    op_en = 1'b0;
  endtask

  task automatic clear_irq();
    @(negedge clk);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    check("irq_clr", irq, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_hs"}, {bus.eng_ready, bus.port_reads_en, bus.cmd_fifo_rd_en, bus.cmd_load_en}, 0);
    check({tag, "_st"}, {op_run, irq, err, cmd_done_count, op_type, padding, stride_1}, 0);
    check({tag, "_addr"}, {writeback_addr, weight_start_addr}, 0);
    check({tag, "_fld"}, {data_start_addr, stride_2, i_kernel_size, o_kernel_size}, 0);
    check({tag, "_ch"}, {i_channel_size, o_channel_size}, 0);
  endtask

  // Follows one command from fetch to retirement.
  task automatic run_cmd(input cmd_t x, input bit is_last);
    logic [2:0] eng;
    int beats;
    int g;
    eng   = exp_eng(x.op);
    beats = exp_beats(x.och);
    g = 0;
    while (bus.eng_ready == 3'b000 && int'(cmd_done_count) == exp_done && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("issue_wait", 64'(g < 200), 64'd1);
    if (eng != 3'b000) begin
      check("eng_ready", bus.eng_ready, eng);
      check("port_mask", bus.port_reads_en, exp_ports(x.op));
      check("op_run", op_run, 1'b1);
      check("fld_w0", {op_type, padding, stride_1, stride_2}, {x.op, x.pad, x.s1, x.s2});
      check("fld_w1", {i_channel_size, o_channel_size}, {x.ich, x.och});
      check("fld_w2", {i_kernel_size, o_kernel_size}, {x.ik, x.ok});
      check("fld_addr", {weight_start_addr, data_start_addr}, {x.wa, x.da});
      check("wb_base", writeback_addr, x.wb);
      for (int b = 0; b < beats; b++) begin
        repeat ($urandom_range(0, 2)) begin
          bus.eng_valid = 3'($urandom) & ~eng;
          @(negedge clk);
        end
        check("ready_hold", bus.eng_ready, eng);
        if (b == beats - 1) check("irq_early", irq, 1'b0);
        bus.eng_valid = eng | (3'($urandom) & ~eng);
        @(negedge clk);
        bus.eng_valid = 3'b000;
      end
      check("ready_drop", {bus.eng_ready, bus.port_reads_en}, 0);
      check("wb_final", writeback_addr, x.wb + 32'(beats * WB_STRIDE));
    end else begin
      run_err = 1'b1;
      check("no_ready", bus.eng_ready, 3'b000);
    end
    exp_done++;
    check("done_cnt", cmd_done_count, 7'(exp_done));
    check("err", err, run_err);
    check("irq", irq, is_last);
    check("op_run_end", op_run, !is_last);
  endtask

  task automatic do_run(input cmd_t q[$]);
    int base;
    base = pops;
    foreach (q[i]) push_words(q[i], 0, 5);
    run_err  = 1'b0;
    exp_done = 0;
    start_run(7'(q.size()), 16'hFFFF);
    foreach (q[i]) run_cmd(q[i], i == q.size() - 1);
    check("pops", pops - base, q.size() * 6);
    clear_irq();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.eng_valid = 3'b000;
    bus.cmd_fifo_wr_count = 16'd0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Single conv command: 64 channels -> 4 beats; load request handshake.
    c = rand_cmd();
    c.op = 3'd1; c.och = 16'd64; c.wb = 32'h1000_0000;
    p0 = pops;
    push_words(c, 0, 5);
    run_err = 1'b0; exp_done = 0;
    start_run(7'd1, 16'd0);
    check("load_set", bus.cmd_load_en, 1'b1);
    bus.cmd_fifo_wr_count = 16'd5;
    @(negedge clk);
    check("load_hold", bus.cmd_load_en, 1'b1);
    bus.cmd_fifo_wr_count = 16'd6;
    @(negedge clk);
    check("load_clr", bus.cmd_load_en, 1'b0);
    run_cmd(c, 1'b1);
    check("conv_wb", writeback_addr, 32'h1000_0100);
    check("conv_pops", pops - p0, 6);
    clear_irq();

    // Three commands on three different engines.
    cs.delete();
    c = rand_cmd(); c.op = 3'd2; c.och = 16'd16; cs.push_back(c);
    c = rand_cmd(); c.op = 3'd4; c.och = 16'd16; cs.push_back(c);
    c = rand_cmd(); c.op = 3'd5; c.och = 16'd16; cs.push_back(c);
    do_run(cs);

    // FIFO runs dry after word 2 of the first command.
    cs.delete();
    c = rand_cmd(); c.op = 3'd3; cs.push_back(c);
    c = rand_cmd(); c.op = 3'd1; cs.push_back(c);
    p0 = pops;
    push_words(cs[0], 0, 2);
    run_err = 1'b0; exp_done = 0;
    start_run(7'd2, 16'hFFFF);
    repeat (8) @(negedge clk);
    check("stall_pops", pops - p0, 3);
    check("stall_ready", bus.eng_ready, 3'b000);
    push_words(cs[0], 3, 5);
    push_words(cs[1], 0, 5);
    run_cmd(cs[0], 1'b0);
    run_cmd(cs[1], 1'b1);
    check("stall_total", pops - p0, 12);
    clear_irq();

    // Invalid op in the first of two commands.
    cs.delete();
    c = rand_cmd(); c.op = 3'd7; cs.push_back(c);
    c = rand_cmd(); c.op = 3'd2; cs.push_back(c);
    do_run(cs);

    // Zero-length run, then irq_clr and op_en together in FINISH.
    p0 = pops;
    start_run(7'd0, 16'd0);
    check("zero_irq", irq, 1'b1);
    check("zero_oprun", op_run, 1'b0);
    repeat (3) @(negedge clk);
    check("zero_pops", pops - p0, 0);
    clear_irq();
    start_run(7'd0, 16'd0);
    @(negedge clk);
    cmd_size = 7'd1; op_en = 1'b1; irq_clr = 1'b1;
    @(negedge clk);
    op_en = 1'b0; irq_clr = 1'b0;
    check("simul_irq", irq, 1'b0);
    repeat (4) @(negedge clk);
    check("simul_noload", {bus.cmd_load_en, bus.cmd_fifo_rd_en, op_run}, 0);

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      cs.delete();
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) cs.push_back(rand_cmd());
      do_run(cs);
    end

    // Reset in the middle of WAIT.
    c = rand_cmd(); c.op = 3'd3; c.och = 16'd64;
    push_words(c, 0, 5);
    start_run(7'd1, 16'hFFFF);
    guard = 0;
    while (bus.eng_ready == 3'b000 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("rst_reach_wait", bus.eng_ready, 3'b001);
    bus.eng_valid = 3'b001;
    @(negedge clk);
    bus.eng_valid = 3'b000;
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    wr_ptr = rd_ptr;
    repeat (2) @(negedge clk);
    check("post_rst_idle", {bus.cmd_fifo_rd_en, bus.eng_ready, irq}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
